// File: rtl/tremolo_pkg.sv
// tremolo_pkg: shared types, constants and the gain law for the tremolo stage.
package tremolo_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_OUT
  } state_t;

  localparam logic [15:0]        GAIN_UNITY = 16'h8000;
  localparam logic [15:0]        GAIN_MID   = 16'h4000;
  localparam logic signed [31:0] ROUND_BIAS = 32'sh4000;

  // Unsigned Q1.15 gain from the LFO top half and the depth setting.
  // The LFO is centred on half gain and clamped to [0, unity] in 18 bits,
  // then the attenuation below unity is scaled by the depth.
  function automatic logic [15:0] calc_gain(input logic [15:0] lfo_top,
                                            input logic [1:0]  depth);
    logic signed [17:0] g_sum;
    logic [15:0]        g_full;
    logic [15:0]        d;
    logic [15:0]        gain;
    g_sum = $signed({2'b00, GAIN_MID}) + $signed({{2{lfo_top[15]}}, lfo_top});
    if (g_sum[17]) begin
      g_full = 16'h0000;
    end else if (g_sum > $signed({2'b00, GAIN_UNITY})) begin
      g_full = GAIN_UNITY;
    end else begin
      g_full = g_sum[15:0];
    end
    d = GAIN_UNITY - g_full;
    case (depth)
      2'd0:    gain = GAIN_UNITY;
      2'd1:    gain = GAIN_UNITY - (d >> 2);
      2'd2:    gain = GAIN_UNITY - (d >> 1);
      default: gain = GAIN_UNITY - d;
    endcase
    return gain;
  endfunction

endpackage

// File: rtl/tremolo_modulator_if.sv
// tremolo_modulator_if: sample-in and sample-out handshakes plus the LFO/depth
// controls that travel with each input sample.
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge; ready may be asserted independently of valid.
interface tremolo_modulator_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_sample;
  logic [31:0] i_lfo;
  logic [1:0]  i_depth;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_sample;

  modport slave (
    input  i_valid, i_sample, i_lfo, i_depth, i_ready,
    output o_ready, o_valid, o_sample
  );

  modport master (
    output i_valid, i_sample, i_lfo, i_depth, i_ready,
    input  o_ready, o_valid, o_sample
  );
endinterface

// File: rtl/seq_mult_s16u16.sv
// seq_mult_s16u16: signed 16 x unsigned 16 shift-add multiplier, one
// multiplier bit per cycle LSB first. start loads the operands and clears the
// accumulator; done is high during the 16th iteration, when product holds the
// complete result.
module seq_mult_s16u16
  import tremolo_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] mcand_in,
  input  logic        [DATA_W-1:0] mplier_in,
  output logic                     done,
  output logic signed [31:0]       product
);

  logic signed [31:0] acc;
  logic signed [31:0] mcand;
  logic [15:0]        mplier;
  logic [3:0]         cnt;
  logic               busy;
  logic signed [31:0] sum;

  // Partial-product add for the current multiplier bit.
  always_comb begin
    sum     = acc + (mplier[0] ? mcand : 32'sd0);
    product = sum;
    done    = busy && (cnt == 4'd15);
  end

  // Iteration registers; the counter wraps to 0 after the last iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{16{mcand_in[15]}}, mcand_in};
      mplier <= mplier_in;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= sum;
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      if (cnt == 4'd15) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tremolo_modulator.sv
// tremolo_modulator: applies a triangle-LFO-driven gain to 16-bit audio
// samples. One sample in flight at a time: capture, gain setup, 16-cycle
// multiply, then hold the result until downstream takes it.
// Build option TREMOLO_ROUND_EN: round half up and clamp instead of truncating.
module tremolo_modulator
  import tremolo_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  tremolo_modulator_if.slave   bus,
  output state_t               dbg_state
);

  state_t             state;
  state_t             next_state;
  logic [15:0]        sample_q;
  logic [15:0]        lfo_top_q;
  logic [1:0]         depth_q;
  logic               valid_q;
  logic [15:0]        out_q;
  logic [15:0]        gain;
  logic [15:0]        out_next;
  logic               mul_start;
  logic               mul_done;
  logic signed [31:0] mul_product;

  // Low half of the LFO word carries no gain information.
  logic unused_lfo_lo;
  assign unused_lfo_lo = ^bus.i_lfo[15:0];

  assign gain = calc_gain(lfo_top_q, depth_q);

  seq_mult_s16u16 u_mult (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (mul_start),
    .mcand_in  ($signed(sample_q)),
    .mplier_in (gain),
    .done      (mul_done),
    .product   (mul_product)
  );

`ifdef TREMOLO_ROUND_EN
  logic signed [31:0] rounded;
  logic signed [31:0] shifted;

  // Round half up, then clamp to the signed 16-bit range.
  always_comb begin
    rounded = mul_product + ROUND_BIAS;
    shifted = rounded >>> 15;
    if (shifted > 32'sh0000_7FFF) begin
      out_next = 16'h7FFF;
    end else if (shifted < 32'shFFFF_8000) begin
      out_next = 16'h8000;
    end else begin
      out_next = shifted[15:0];
    end
  end
`else
  // Truncate: arithmetic floor of product / 2^15.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{mul_product[31], mul_product[14:0]};
  assign out_next = mul_product[30:15];
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.i_valid) next_state = S_LOAD;
      S_LOAD:  next_state = S_MUL;
      S_MUL:   if (mul_done) next_state = S_OUT;
      S_OUT:   if (bus.i_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.o_ready  = (state == S_IDLE);
    mul_start    = (state == S_LOAD);
    dbg_state    = state;
    bus.o_valid  = valid_q;
    bus.o_sample = out_q;
  end

  // Input capture at accept; result register loaded on the last iteration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_q  <= '0;
      lfo_top_q <= '0;
      depth_q   <= '0;
      valid_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      if (state == S_IDLE && bus.i_valid) begin
        sample_q  <= bus.i_sample;
        lfo_top_q <= bus.i_lfo[31:16];
        depth_q   <= bus.i_depth;
      end
      if (state == S_MUL && mul_done) begin
        valid_q <= 1'b1;
        out_q   <= out_next;
      end else if (state == S_OUT && bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tremolo_modulator.md
# tremolo_modulator

Amplitude-modulation (tremolo) stage that consumes the 32-bit signed triangle LFO word from the effect chain's LFO generator and applies it as a time-varying gain to 16-bit signed audio samples. It sits between the codec receive path and the output mixer. Samples enter and leave through valid/ready handshakes, and each accepted sample is scaled by a sequential shift-add multiplier.

## Interface
- DATA_W, 16, audio sample width (fixed; other values unsupported)
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample (high only in S_IDLE)
- i_sample  in  16  signed audio sample
- i_lfo  in  32  signed LFO word; nominal range ±0x4000_0000
- i_depth  in  2  modulation depth: 0 bypass, 1 quarter, 2 half, 3 full
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream accepts output
- o_sample  out  16  signed modulated sample

## Operation
- FSM states:
  - S_IDLE: o_ready=1. On i_valid, capture i_sample, i_lfo[31:16] (lfo_top) and i_depth, then go to S_LOAD.
  - S_LOAD: compute the gain, clear the accumulator, then go to S_MUL.
  - S_MUL: 16 iterations of the shift-add multiplier, one gain bit per cycle LSB first, then go to S_OUT.
  - S_OUT: o_valid=1 and o_sample is held. On i_ready, go to S_IDLE.
- Gain arithmetic (unsigned Q1.15, unity = 0x8000):
  - g_full = clamp(0x4000 + sign-extended lfo_top, 0, 0x8000), computed in 18 bits before clamping.
  - d = 0x8000 − g_full.
  - gain = 0x8000 for depth 0, 0x8000 − (d>>2) for depth 1, 0x8000 − (d>>1) for depth 2, 0x8000 − d for depth 3.
- Product: signed 16 × unsigned 16 gives a 32-bit signed accumulator. o_sample = product >>> 15, keeping bits [30:15].
- The gain never exceeds 0x8000, so the output magnitude never exceeds the input magnitude and no saturation is needed without rounding.
- i_lfo and i_depth are used only at the accept edge. Changes during S_LOAD, S_MUL or S_OUT have no effect on the sample in flight.

## Timing
- Reset (async, asserted): state S_IDLE, o_valid=0, o_sample=0, accumulator 0, iteration counter 0. o_ready is decoded from state, so it is 1 as soon as i_rst deasserts.
- Reset mid-operation aborts the sample in flight with no output. The first i_valid after reset release is accepted normally.
- Accept happens on a rising edge with i_valid & o_ready. o_valid rises exactly 17 edges later (1 S_LOAD + 16 S_MUL).
- o_valid and o_sample are registered and stable while i_ready=0; the stall length is unbounded.
- S_OUT exits on the first edge with i_ready=1, and o_valid falls on that edge. o_ready is 1 in the next cycle.
- Minimum period is 19 cycles per sample. i_valid while not S_IDLE is ignored; the upstream must hold the sample until accepted.
- Counter: 4-bit, counts 0..15 in S_MUL. Wraps to 0 when entering S_OUT.

## Configuration
- TREMOLO_ROUND_EN defined: round half up. Add 0x4000 to the product before >>>15, then clamp the result to [−32768, 32767].
- TREMOLO_ROUND_EN undefined: truncate (arithmetic floor), no adder and no clamp.
- Latency is identical in both builds.

## Structure
- Package tremolo_pkg holds:
  - state enum {S_IDLE, S_LOAD, S_MUL, S_OUT}
  - GAIN_UNITY = 16'h8000
  - GAIN_MID = 16'h4000
  - ROUND_BIAS = 32'sh4000
- Sub-module seq_mult_s16u16 is the start/done shift-add multiplier. The top level keeps the FSM, gain computation and handshakes.

## Test plan
- Reset, then sample 0x1234 with depth 0 and any i_lfo -> o_sample 0x1234, and o_valid 17 edges after accept.
- i_lfo 0xC000_0000 (lfo_top −0x4000), depth 3, sample 0x7FFF -> gain 0, o_sample 0x0000. Same with i_lfo 0x4000_0000 -> gain 0x8000, o_sample 0x7FFF.
- i_lfo 0x0000_0000, depth 3, sample 3 -> 1 without the macro, 2 with TREMOLO_ROUND_EN. Sample −3 -> −2 without the macro, −1 with it.
- Out-of-range LFO: i_lfo 0x7FFF_0000, depth 3, sample −32768 -> gain clamped to 0x8000, o_sample −32768 (0x8000).
- Backpressure: hold i_ready=0 for 50 cycles in S_OUT while toggling i_valid and i_lfo -> o_sample stable, o_ready=0, no extra accept. Release -> exactly one transfer.
- Assert i_rst at S_MUL iteration 8 -> o_valid=0, o_sample=0, no output ever produced for that sample. The next sample is processed correctly.
